// File: rtl/wts_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : wts_scheduler_pkg
//  Purpose  : Shared constants and the key-event code type for the
//             5-channel envelope slot scheduler.
//  Contents : WTS_CH_COUNT, WTS_SLOT_IDLE, wts_event_e (EV_NONE/ON/RELEASE/OFF)
//  Revision : 1.0  initial release
// ============================================================================
package wts_scheduler_pkg;

    localparam int         WTS_CH_COUNT  = 5;
    localparam logic [2:0] WTS_SLOT_IDLE = 3'd5;

    // Held request code per channel. EV_NONE doubles as "nothing pending".
    typedef enum logic [1:0] {
        EV_NONE    = 2'd0,
        EV_ON      = 2'd1,
        EV_RELEASE = 2'd2,
        EV_OFF     = 2'd3
    } wts_event_e;

endpackage
`default_nettype wire

// File: rtl/wts_key_event_latch.sv
`default_nettype none
// ============================================================================
//  Module   : wts_key_event_latch
//  Purpose  : One channel's request latch. Holds the latest key event until
//             the channel's slot serves it.
//  Ports    : clk, reset        - clock, async active-high reset
//             i_on_req          - key-on request pulse
//             i_release_req     - key-release request pulse
//             i_off_req         - key-off request pulse
//             i_serve           - this edge loads the channel's slot
//             o_code            - currently held event code
//             o_pending         - registered "un-served event held" flag
//  Revision : 1.0  initial release
// ============================================================================
module wts_key_event_latch
    import wts_scheduler_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_on_req,
    input  logic       i_release_req,
    input  logic       i_off_req,
    input  logic       i_serve,
    output wts_event_e o_code,
    output logic       o_pending
);

    wts_event_e code_d, code_q;
    logic       pending_d, pending_q;

    // A request arriving on the serve edge wins over the clear, so it stays
    // pending for the next frame. Same-cycle priority: off > on > release.
    always_comb begin
        code_d = code_q;
        if (i_off_req) begin
            code_d = EV_OFF;
        end else if (i_on_req) begin
            code_d = EV_ON;
        end else if (i_release_req) begin
            code_d = EV_RELEASE;
        end else if (i_serve) begin
            code_d = EV_NONE;
        end
        pending_d = (code_d != EV_NONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            code_q    <= EV_NONE;
            pending_q <= 1'b0;
        end else begin
            code_q    <= code_d;
            pending_q <= pending_d;
        end
    end

    assign o_code    = code_q;
    assign o_pending = pending_q;

endmodule
`default_nettype wire

// File: rtl/wts_channel_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : wts_channel_scheduler
//  Purpose  : Time-slot scheduler for the shared 5-channel envelope engine.
//             Steps active through 0..4 then IDLE_SLOTS cycles of slot 5,
//             serves held key events in each channel's slot and captures the
//             per-channel envelope level.
//  Ports    : clk, reset                  - clock, async active-high reset
//             enable                      - run (1) / park in idle slot (0)
//             key_on/release/off_req[4:0] - request pulses, bit0 = ch A
//             envelope[4:0]               - level for the channel in `active`
//             active[2:0]                 - slot index, 5 = no operation
//             key_on/release/off[4:0]     - served events, one slot wide
//             pending[4:0]                - un-served event held per channel
//             frame_start                 - high while active = 0
//             env_level_a..e[4:0]         - captured level per channel
//  Revision : 1.0  initial release
// ============================================================================
module wts_channel_scheduler
    import wts_scheduler_pkg::*;
#(
    parameter int IDLE_SLOTS = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [4:0] key_on_req,
    input  logic [4:0] key_release_req,
    input  logic [4:0] key_off_req,
    input  logic [4:0] envelope,
    output logic [2:0] active,
    output logic [4:0] key_on,
    output logic [4:0] key_release,
    output logic [4:0] key_off,
    output logic [4:0] pending,
    output logic       frame_start,
    output logic [4:0] env_level_a,
    output logic [4:0] env_level_b,
    output logic [4:0] env_level_c,
    output logic [4:0] env_level_d,
    output logic [4:0] env_level_e
);

    // Idle counter counts down the remaining idle cycles after the current one.
    localparam logic [7:0] C_IDLE_LOAD = 8'(IDLE_SLOTS - 1);

    logic [2:0] active_d, active_q;
    logic [7:0] idle_cnt_d, idle_cnt_q;
    logic [4:0] key_on_d, key_on_q;
    logic [4:0] key_release_d, key_release_q;
    logic [4:0] key_off_d, key_off_q;
    logic       frame_start_d, frame_start_q;
    logic [4:0] env_d [WTS_CH_COUNT];
    logic [4:0] env_q [WTS_CH_COUNT];

    logic [4:0] serve;
    wts_event_e code [WTS_CH_COUNT];

    // Slot sequencing. A zero idle count while parked in slot 5 (after reset
    // or a disable) makes the next enabled edge start a fresh frame.
    always_comb begin
        active_d   = active_q;
        idle_cnt_d = idle_cnt_q;
        if (!enable) begin
            active_d   = WTS_SLOT_IDLE;
            idle_cnt_d = '0;
        end else if (active_q == WTS_SLOT_IDLE) begin
            if (idle_cnt_q == '0) begin
                active_d = 3'd0;
            end else begin
                idle_cnt_d = idle_cnt_q - 8'd1;
            end
        end else if (active_q == 3'd4) begin
            active_d   = WTS_SLOT_IDLE;
            idle_cnt_d = C_IDLE_LOAD;
        end else begin
            active_d = active_q + 3'd1;
        end
        frame_start_d = (active_d == 3'd0);
    end

    genvar k;
    generate
        for (k = 0; k < WTS_CH_COUNT; k++) begin : g_ch
            // Service happens on the edge that loads this channel's slot.
            assign serve[k] = (active_d == 3'(k));

            wts_key_event_latch u_latch (
                .clk           (clk),
                .reset         (reset),
                .i_on_req      (key_on_req[k]),
                .i_release_req (key_release_req[k]),
                .i_off_req     (key_off_req[k]),
                .i_serve       (serve[k]),
                .o_code        (code[k]),
                .o_pending     (pending[k])
            );

            always_comb begin
                key_on_d[k]      = serve[k] && (code[k] == EV_ON);
                key_release_d[k] = serve[k] && (code[k] == EV_RELEASE);
                key_off_d[k]     = serve[k] && (code[k] == EV_OFF);
                env_d[k]         = (enable && (active_q == 3'(k))) ? envelope : env_q[k];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_q      <= WTS_SLOT_IDLE;
            idle_cnt_q    <= '0;
            key_on_q      <= '0;
            key_release_q <= '0;
            key_off_q     <= '0;
            frame_start_q <= 1'b0;
            for (int i = 0; i < WTS_CH_COUNT; i++) begin
                env_q[i] <= '0;
            end
        end else begin
            active_q      <= active_d;
            idle_cnt_q    <= idle_cnt_d;
            key_on_q      <= key_on_d;
            key_release_q <= key_release_d;
            key_off_q     <= key_off_d;
            frame_start_q <= frame_start_d;
            for (int i = 0; i < WTS_CH_COUNT; i++) begin
                env_q[i] <= env_d[i];
            end
        end
    end

    assign active      = active_q;
    assign key_on      = key_on_q;
    assign key_release = key_release_q;
    assign key_off     = key_off_q;
    assign frame_start = frame_start_q;
    assign env_level_a = env_q[0];
    assign env_level_b = env_q[1];
    assign env_level_c = env_q[2];
    assign env_level_d = env_q[3];
    assign env_level_e = env_q[4];

endmodule
`default_nettype wire

// File: doc/wts_channel_scheduler.md
# wts_channel_scheduler

Time-slot scheduler for the shared 5-channel ADSR envelope datapath. It generates the `active` slot index that steps channels A–E through the single envelope engine, followed by a programmable run of idle slots. It holds per-channel key-on/release/off requests from the register interface until that channel's slot comes round. It also captures the envelope level presented for each channel into per-channel registers for the mixer.

## Interface
Parameters:
- `IDLE_SLOTS`, default 1: cycles per frame spent at `active`=5 (no operation); legal range 1..255.

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `reset` in 1: reset is asynchronous and active-high.
- `enable` in 1: 1 = run the slot sequence; 0 = park in the idle slot.
- `key_on_req` in 5: single-cycle request pulses; bit0 = ch A … bit4 = ch E.
- `key_release_req` in 5: as above.
- `key_off_req` in 5: as above.
- `envelope` in 5: level of the channel currently selected by `active`, driven by the envelope engine.
- `active` out 3: slot index; 0..4 = channel A..E, 5 = no operation.
- `key_on` out 5: bit k is high only during the cycle in which `active`=k.
- `key_release` out 5: as above.
- `key_off` out 5: as above.
- `pending` out 5: bit k = an un-served request is held for channel k.
- `frame_start` out 1: high during the cycle in which `active`=0.
- `env_level_a` … `env_level_e` out 5 each: last captured level per channel.

## Operation
- Frame: `active` 0,1,2,3,4, then 5 for IDLE_SLOTS cycles, then repeats. Frame length = 5+IDLE_SLOTS cycles.
- Request latch, per channel, holds one pending event code: none / on / release / off.
  - A request on any cycle overwrites the held code (latest wins).
  - Same-cycle priority is off > on > release.
- Service:
  - At the edge that loads `active`=k, the held code of channel k is copied into the registered `key_*`[k] output and the latch is cleared.
  - Every other `key_*` bit is 0 at that time.
  - A request sampled at that same edge is not served. It remains pending for the next frame and overrides per the latest-wins rule.
- Envelope capture: at each edge where the current `active`=k (0..4), `env_level_k` <= `envelope`. No capture while `active`=5.
- `enable` low:
  - At the next edge `active` goes to 5 and holds there.
  - `key_*` outputs are 0, latches keep accepting requests, and `env_level_*` hold.
- `enable` returning high: the next edge loads `active`=0 and the idle counter restarts.

## Timing
- Reset values: `active`=5, `key_on`/`key_release`/`key_off`=0, `pending`=0, `frame_start`=0, all `env_level_*`=0, idle counter=0.
- First edge after reset release with `enable`=1 loads `active`=0.
- All outputs are registered. `key_*`[k], `frame_start` and `active` change on the same edge.
- Request-to-service latency: minimum 2 cycles, maximum 6+IDLE_SLOTS cycles.
- Envelope-to-`env_level` latency is 1 cycle after the channel's slot.
- `pending`[k] falls on the edge that raises `key_*`[k], unless a new request arrives at that edge.
- Reset asserted mid-frame: all state returns immediately to reset values and un-served requests are discarded.
- IDLE_SLOTS=1: frame is exactly 6 cycles, with no back-to-back idle cycles.

## Structure
- Package `wts_scheduler_pkg` holds:
  - `WTS_CH_COUNT`=5, `WTS_SLOT_IDLE`=3'd5.
  - Event-code constants `EV_NONE`/`EV_ON`/`EV_RELEASE`/`EV_OFF` (2 bits).
- Sub-module `wts_key_event_latch`: one channel's request latch (priority, latest-wins, clear-on-serve, pending flag). Instantiated 5 times.
- Top level contains the slot/idle counters, output registers and envelope capture registers.

## Test plan
- Reset, IDLE_SLOTS=1, `enable`=1 → `active` = 5,0,1,2,3,4,5,0…; `frame_start` high once every 6 cycles, coincident with `active`=0.
- `key_on_req`=5'b00100 pulsed while `active`=0 → `pending`[2] high next cycle; `key_on`=5'b00100 exactly in the `active`=2 cycle; `pending`[2] low in that same cycle.
- `key_off_req`[1] pulsed in the cycle with `active`=0 → not served at `active`=1; `key_off`[1] high at `active`=1 of the following frame.
- `key_on_req`[0] and `key_off_req`[0] in the same cycle → only `key_off`[0] at the next `active`=0.
- `key_on_req`[0] followed by `key_release_req`[0] before service → only `key_release`[0] at the next `active`=0.
- `envelope`=17 during `active`=3, 0 elsewhere → `env_level_d`=17 one cycle later; the other four levels stay 0.
- `enable` dropped while `active`=2, with `key_on_req`[4] pulsed while it is low → `active` 5 held and `pending`[4]=1. After `enable` rises → `active`=0 on the next edge, then `key_on`[4] at `active`=4.
